// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } ctrl_state_t;

  localparam int NIBBLE = 4;

endpackage

// File: rtl/csa_nibble_slice.sv
// Combinational 4-bit carry-select slice: both carry hypotheses are
// precomputed and Cin picks one, so Cin only drives the final mux.
module csa_nibble_slice
  import adder_pkg::*;
(
  input  logic [NIBBLE-1:0] A,
  input  logic [NIBBLE-1:0] B,
  input  logic              Cin,
  output logic [NIBBLE-1:0] Sum,
  output logic              Cout
);

  logic [NIBBLE:0] res_c0;
  logic [NIBBLE:0] res_c1;

  assign res_c0 = {1'b0, A} + {1'b0, B};
  assign res_c1 = {1'b0, A} + {1'b0, B} + {{NIBBLE{1'b0}}, 1'b1};

  assign {Cout, Sum} = Cin ? res_c1 : res_c0;

endmodule

// File: rtl/csa_serial_adder_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single
// carry-select slice, LS nibble first, under a Run/Done pushbutton handshake.
module csa_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int NUM_NIB = WIDTH / NIBBLE;
  localparam int CNT_W   = $clog2(NUM_NIB);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_NIB - 1);

  ctrl_state_t       state;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  s_sh;
  logic [CNT_W-1:0]  cnt;
  logic              carry;
  logic              a_msb;
  logic              bx_msb;

  logic [NIBBLE-1:0] slice_sum;
  logic              slice_cout;
  logic [WIDTH-1:0]  s_next;

  csa_nibble_slice u_slice (
    .A    (a_sh[NIBBLE-1:0]),
    .B    (b_sh[NIBBLE-1:0]),
    .Cin  (carry),
    .Sum  (slice_sum),
    .Cout (slice_cout)
  );

  // Result fills from the top so the first nibble ends up at the bottom.
  assign s_next = {slice_sum, s_sh[WIDTH-1:NIBBLE]};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      a_msb    <= 1'b0;
      bx_msb   <= 1'b0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Run) begin
            // Subtraction is A + ~B + 1, with the +1 entering as carry-in.
            a_sh   <= A;
            b_sh   <= Sub ? ~B : B;
            a_msb  <= A[WIDTH-1];
            bx_msb <= Sub ? ~B[WIDTH-1] : B[WIDTH-1];
            carry  <= Sub;
            cnt    <= '0;
            Busy   <= 1'b1;
            state  <= COMPUTE;
          end
        end
        COMPUTE: begin
          a_sh  <= a_sh >> NIBBLE;
          b_sh  <= b_sh >> NIBBLE;
          s_sh  <= s_next;
          carry <= slice_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            Sum      <= s_next;
            Cout     <= slice_cout;
            Overflow <= a_msb ^ bx_msb ^ s_next[WIDTH-1] ^ slice_cout;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            cnt      <= '0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (!Run) begin
            Done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
